// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator processor controller: FSM state
// encoding, opcode values and accumulator-source selections.
package cpu_pkg;

    typedef enum logic [3:0] {
        START,
        FETCH,
        DECODE,
        LOAD,
        STORE,
        ADD,
        SUB,
        IN,
        JZ,
        JPOS,
        HALT,
        PIDLE,
        PLATCH,
        PWRITE
    } state_t;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_IN    = 3'b100;
    localparam logic [2:0] OP_JZ    = 3'b101;
    localparam logic [2:0] OP_JPOS  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam logic [1:0] ASEL_ALU   = 2'b00;
    localparam logic [1:0] ASEL_INPUT = 2'b01;
    localparam logic [1:0] ASEL_RAM   = 2'b10;
    localparam logic [1:0] ASEL_ZERO  = 2'b11;

    // Each opcode dispatches to the execute state that carries its name.
    function automatic state_t exec_state(input logic [2:0] op);
        case (op)
            OP_LOAD:  return LOAD;
            OP_STORE: return STORE;
            OP_ADD:   return ADD;
            OP_SUB:   return SUB;
            OP_IN:    return IN;
            OP_JZ:    return JZ;
            OP_JPOS:  return JPOS;
            default:  return HALT;
        endcase
    endfunction

endpackage

// File: rtl/enter_pulse.sv
// Turns the Enter push-button level into a one-cycle registered pulse.
// Optional macro CU_ENTER_SYNC_EN inserts a 2-flop synchronizer in front.
module enter_pulse (
    input  logic clk,
    input  logic rst,
    input  logic enter,
    output logic pulse
);

    logic sample;
    logic prev_q, prev_d;
    logic pulse_q, pulse_d;

`ifdef CU_ENTER_SYNC_EN
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    always_comb begin
        sync1_d = enter;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign sample = sync2_q;
`else
    assign sample = enter;
`endif

    // Registering the edge keeps the pulse exactly one cycle wide even when
    // the button is held.
    always_comb begin
        prev_d  = sample;
        pulse_d = sample & ~prev_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute and program-load controller for the 8-bit accumulator
// datapath. Enter synchronization is selected by CU_ENTER_SYNC_EN in enter_pulse.
module control_unit
    import cpu_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Enter,
    input  logic       ProgMode,
    input  logic [2:0] IR,
    input  logic       Aeq0,
    input  logic       Apos,
    output logic       IRload,
    output logic       PCload,
    output logic       JMPmux,
    output logic       Meminst,
    output logic       MemWr,
    output logic       Aload,
    output logic       Sub,
    output logic       Halt,
    output logic [1:0] Asel,
    output logic       programEn,
    output logic       Addrload,
    output logic       PRload,
    output logic [4:0] AddrSel
);

    state_t     state_q, state_d;
    logic [4:0] addr_q, addr_d;
    logic       enter_hit;

    enter_pulse u_enter_pulse (
        .clk   (Clock),
        .rst   (Reset),
        .enter (Enter),
        .pulse (enter_hit)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= START;
            addr_q  <= 5'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // ProgMode is only consulted in START and PIDLE, so a mid-flow change waits
    // for the next visit to one of those states.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            START:  state_d = ProgMode ? PIDLE : FETCH;
            FETCH:  state_d = DECODE;
            DECODE: state_d = exec_state(IR);
            LOAD, STORE, ADD, SUB, JZ, JPOS: state_d = START;
            IN: begin
                if (enter_hit) begin
                    state_d = START;
                end
            end
            HALT:   state_d = HALT;
            PIDLE: begin
                if (!ProgMode) begin
                    state_d = START;
                end else if (enter_hit) begin
                    state_d = PLATCH;
                end
            end
            PLATCH: state_d = PWRITE;
            PWRITE: begin
                state_d = PIDLE;
                addr_d  = addr_q + 5'd1;
            end
            default: state_d = START;
        endcase
    end

    always_comb begin
        IRload    = 1'b0;
        PCload    = 1'b0;
        JMPmux    = 1'b0;
        Meminst   = 1'b0;
        MemWr     = 1'b0;
        Aload     = 1'b0;
        Sub       = 1'b0;
        Halt      = 1'b0;
        Asel      = ASEL_ALU;
        programEn = 1'b0;
        Addrload  = 1'b0;
        PRload    = 1'b0;
        case (state_q)
            FETCH: begin
                IRload = 1'b1;
                PCload = 1'b1;
            end
            LOAD: begin
                Meminst = 1'b1;
                Asel    = ASEL_RAM;
                Aload   = 1'b1;
            end
            STORE: begin
                Meminst = 1'b1;
                MemWr   = 1'b1;
            end
            ADD: begin
                Meminst = 1'b1;
                Aload   = 1'b1;
            end
            SUB: begin
                Meminst = 1'b1;
                Sub     = 1'b1;
                Aload   = 1'b1;
            end
            IN: begin
                Asel  = ASEL_INPUT;
                Aload = enter_hit;
            end
            JZ: begin
                JMPmux = 1'b1;
                PCload = Aeq0;
            end
            JPOS: begin
                JMPmux = 1'b1;
                PCload = Apos;
            end
            HALT:   Halt = 1'b1;
            PLATCH: begin
                Addrload = 1'b1;
                PRload   = 1'b1;
            end
            PWRITE: programEn = 1'b1;
            default: ;
        endcase
    end

    assign AddrSel = addr_q;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: a transaction-level model pushes the
// expected control vector for every cycle; a negedge monitor pops and compares.
module tb_control_unit;

`ifdef CU_ENTER_SYNC_EN
   localparam int ENTER_LAT = 3;
`else
   localparam int ENTER_LAT = 1;
`endif

   localparam logic [2:0] OPC_LOAD  = 3'd0;
   localparam logic [2:0] OPC_STORE = 3'd1;
   localparam logic [2:0] OPC_ADD   = 3'd2;
   localparam logic [2:0] OPC_SUB   = 3'd3;
   localparam logic [2:0] OPC_IN    = 3'd4;
   localparam logic [2:0] OPC_JZ    = 3'd5;
   localparam logic [2:0] OPC_JPOS  = 3'd6;
   localparam logic [2:0] OPC_HALT  = 3'd7;

   typedef logic [17:0] vec_t;

   logic       clock = 1'b0;
   logic       reset;
   logic       enter;
   logic       progMode;
   logic [2:0] ir;
   logic       aeq0;
   logic       apos;
   logic       irLoad, pcLoad, jmpMux, memInst, memWr, aLoad, subOut, haltOut;
   logic [1:0] aSel;
   logic       programEn, addrLoad, prLoad;
   logic [4:0] addrSel;
   vec_t       actual;

   vec_t expQ[$];
   int   checkCount = 0;
   int   passCount = 0;
   int   cyc = 0;
   int   resetCyc = 0;
   int   addrModel = 0;
   int   genHold = 0;
   logic genLevel = 1'b0;
   logic enterLog [0:65535];

   control_unit dut (
      .Clock     (clock),
      .Reset     (reset),
      .Enter     (enter),
      .ProgMode  (progMode),
      .IR        (ir),
      .Aeq0      (aeq0),
      .Apos      (apos),
      .IRload    (irLoad),
      .PCload    (pcLoad),
      .JMPmux    (jmpMux),
      .Meminst   (memInst),
      .MemWr     (memWr),
      .Aload     (aLoad),
      .Sub       (subOut),
      .Halt      (haltOut),
      .Asel      (aSel),
      .programEn (programEn),
      .Addrload  (addrLoad),
      .PRload    (prLoad),
      .AddrSel   (addrSel)
   );

   always #5 clock = ~clock;

   assign actual = {irLoad, pcLoad, jmpMux, memInst, memWr, aLoad, subOut, haltOut,
                    aSel, programEn, addrLoad, prLoad, addrSel};

   // Expected control vector in the same field order as 'actual'; AddrSel
   // comes from the model's count of words written so far.
   function automatic vec_t mk(input logic irl, input logic pcl, input logic jmp,
                               input logic mi, input logic mw, input logic al,
                               input logic sb, input logic hlt, input logic [1:0] asel,
                               input logic pe, input logic adl, input logic prl);
      int a;
      logic [4:0] addr;
      a = addrModel % 32;
      addr = a[4:0];
      return {irl, pcl, jmp, mi, mw, al, sb, hlt, asel, pe, adl, prl, addr};
   endfunction

   function automatic vec_t idleVec();
      return mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
   endfunction

   // The button pulse reaches the controller ENTER_LAT edges after a rising
   // level; anything before the last reset counts as a low level.
   function automatic logic pulseNow();
      int i;
      i = cyc - ENTER_LAT;
      if (i < resetCyc || !enterLog[i]) return 1'b0;
      if (i - 1 < resetCyc) return 1'b1;
      return !enterLog[i - 1];
   endfunction

   // What the execute step of each instruction asks of the datapath.
   function automatic vec_t execVec(input logic [2:0] op, input logic p);
      case (op)
         OPC_LOAD:  return mk(0, 0, 0, 1, 0, 1, 0, 0, 2'b10, 0, 0, 0);
         OPC_STORE: return mk(0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0);
         OPC_ADD:   return mk(0, 0, 0, 1, 0, 1, 0, 0, 2'b00, 0, 0, 0);
         OPC_SUB:   return mk(0, 0, 0, 1, 0, 1, 1, 0, 2'b00, 0, 0, 0);
         OPC_IN:    return mk(0, 0, 0, 0, 0, p, 0, 0, 2'b01, 0, 0, 0);
         OPC_JZ:    return mk(0, aeq0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
         OPC_JPOS:  return mk(0, apos, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
         default:   return mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0);
      endcase
   endfunction

   task automatic checkOutput(input string name, input vec_t act, input vec_t exp);
      checkCount++;
      if (act === exp) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
      end
   endtask

   task automatic failBound(input string name);
      checkCount++;
      $display("[TB] FAIL %s: bound expired at cycle %0d", name, cyc);
   endtask

   // The monitor compares whatever the model queued for the current cycle.
   always @(negedge clock) begin
      if (expQ.size() > 0) begin
         vec_t e;
         e = expQ.pop_front();
         checkOutput("ctrl", actual, e);
      end
   end

   task automatic randFlags();
      aeq0 = 1'($urandom);
      apos = 1'($urandom);
   endtask

   task automatic nextEnter();
      if (genHold == 0) begin
         genLevel = !genLevel;
         genHold = genLevel ? int'($urandom_range(1, 20)) : int'($urandom_range(1, 4));
      end
      genHold--;
      enter = genLevel;
   endtask

   // Inputs for this cycle are already driven; queue the expected response
   // and advance to just after the next rising edge.
   task automatic applyStimulus(input vec_t exp);
      if (cyc >= 65535) begin
         $display("[TB] FAIL cycle budget exhausted");
         $fatal(1, "[TB] cycle budget exhausted");
      end
      enterLog[cyc] = enter;
      expQ.push_back(exp);
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic runInstr(input logic [2:0] op);
      logic p;
      int waitCnt;
      progMode = 1'b0;
      enter = 1'b0;
      ir = 3'($urandom);
      randFlags();
      applyStimulus(idleVec());
      progMode = 1'($urandom);
      ir = op;
      randFlags();
      applyStimulus(mk(1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
      progMode = 1'($urandom);
      randFlags();
      applyStimulus(idleVec());
      if (op == OPC_IN) begin
         waitCnt = $urandom_range(1, 4);
         for (int k = 0; k < 60; k++) begin
            enter = (k >= waitCnt);
            progMode = 1'($urandom);
            ir = 3'($urandom);
            randFlags();
            p = pulseNow();
            applyStimulus(execVec(op, p));
            if (p) break;
            if (k == 59) failBound("IN wait");
         end
      end else begin
         enter = 1'($urandom);
         progMode = 1'($urandom);
         ir = 3'($urandom);
         randFlags();
         applyStimulus(execVec(op, 1'b0));
      end
   endtask

   task automatic progWords(input int n);
      int words;
      int guard;
      logic p;
      progMode = 1'b1;
      nextEnter();
      randFlags();
      applyStimulus(idleVec());
      words = 0;
      guard = 0;
      while (words < n && guard < 5000) begin
         guard++;
         progMode = 1'b1;
         nextEnter();
         randFlags();
         ir = 3'($urandom);
         p = pulseNow();
         applyStimulus(idleVec());
         if (p) begin
            nextEnter();
            progMode = 1'($urandom);
            applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 1));
            nextEnter();
            progMode = 1'($urandom);
            applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0));
            addrModel = (addrModel + 1) % 32;
            words++;
         end
      end
      if (words < n) failBound("program load");
      progMode = 1'b0;
      nextEnter();
      applyStimulus(idleVec());
   endtask

   // Asynchronous reset mid-cycle: outputs must clear before the next edge.
   task automatic doReset(input string name);
      #2;
      reset = 1'b1;
      addrModel = 0;
      #1;
      checkOutput(name, actual, idleVec());
      @(posedge clock);
      #1;
      reset = 1'b0;
      resetCyc = cyc;
   endtask

   task automatic resetMidFetch();
      progMode = 1'b0;
      enter = 1'b0;
      randFlags();
      applyStimulus(idleVec());
      ir = 3'($urandom);
      doReset("reset mid-FETCH");
   endtask

   task automatic resetMidWrite();
      logic p;
      progMode = 1'b1;
      enter = 1'b0;
      applyStimulus(idleVec());
      enter = 1'b1;
      for (int k = 0; k < 10; k++) begin
         p = pulseNow();
         applyStimulus(idleVec());
         if (p) break;
         if (k == 9) failBound("PIDLE wait");
      end
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 1));
      doReset("reset mid-PWRITE");
      enter = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      enter = 1'b0;
      progMode = 1'b0;
      ir = 3'd0;
      aeq0 = 1'b0;
      apos = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      checkOutput("reset state", actual, idleVec());
      reset = 1'b0;
      resetCyc = cyc;

      progWords(3);
      runInstr(OPC_LOAD);
      runInstr(OPC_ADD);
      runInstr(OPC_STORE);
      runInstr(OPC_SUB);
      runInstr(OPC_IN);
      runInstr(OPC_JZ);
      runInstr(OPC_IN);
      runInstr(OPC_JZ);
      repeat (4) runInstr(OPC_JPOS);
      resetMidFetch();
      progWords(36);
      resetMidWrite();
      repeat (60) begin
         if ($urandom_range(0, 7) == 0) progWords(int'($urandom_range(1, 4)));
         else runInstr(3'($urandom_range(0, 6)));
      end

      runInstr(OPC_HALT);
      repeat (8) begin
         enter = 1'($urandom);
         progMode = 1'($urandom);
         ir = 3'($urandom);
         randFlags();
         applyStimulus(execVec(OPC_HALT, 1'b0));
      end
      doReset("reset from HALT");
      runInstr(OPC_LOAD);

      if (expQ.size() != 0) failBound("scoreboard drain");
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
